// File: rtl/simon_engine_if.sv
// Player-facing signal bundle for the Simon game engine.
// start is a level request taken only in IDLE/WIN/LOSE; all outputs are valid on every cycle.
interface simon_engine_if #(
  parameter int NUM_BTN = 4
);
  logic               start;
  logic [15:0]        seed;
  logic [NUM_BTN-1:0] btn;
  logic [NUM_BTN-1:0] led;
  logic [2:0]         state;
  logic [6:0]         level;
  logic               busy;
  logic               win;
  logic               lose;

  modport master (
    output start, seed, btn,
    input  led, state, level, busy, win, lose
  );

  modport slave (
    input  start, seed, btn,
    output led, state, level, busy, win, lose
  );
endinterface

// File: rtl/simon_engine.sv
// Simon memory game: LFSR-generated sequence, timed LED replay, and player input checking.
module simon_engine #(
  parameter int NUM_BTN       = 4,
  parameter int MAX_LEN       = 16,
  parameter int SHOW_TICKS    = 50,
  parameter int GAP_TICKS     = 25,
  parameter int TIMEOUT_TICKS = 500
) (
  input  logic           hz100,
  input  logic           reset,
  simon_engine_if.slave  bus
);

  localparam int BW    = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;
  localparam int IW    = $clog2(MAX_LEN);
  localparam int MAXT0 = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
  localparam int MAXT  = (MAXT0 > TIMEOUT_TICKS) ? MAXT0 : TIMEOUT_TICKS;
  localparam int CW    = $clog2(MAXT + 1);
  localparam logic [15:0] LFSR_INIT = 16'hACE1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GEN      = 3'd1,
    S_SHOW_ON  = 3'd2,
    S_SHOW_OFF = 3'd3,
    S_INPUT    = 3'd4,
    S_WIN      = 3'd5,
    S_LOSE     = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [6:0]         level_q, level_d;
  logic [6:0]         idx_q, idx_d;
  logic [6:0]         ptr_q, ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               win_q, win_d;
  logic               lose_q, lose_d;
  logic [NUM_BTN-1:0] sync1_q, sync2_q, prev_q;
  logic [BW-1:0]      seq_q [MAX_LEN];
  logic               seq_we;
  logic [NUM_BTN-1:0] led_c;

  logic [NUM_BTN-1:0] rise;
  logic [BW-1:0]      show_sel;
  logic [BW-1:0]      exp_sel;
  logic [15:0]        lfsr_next;

  function automatic logic [NUM_BTN-1:0] onehot(input logic [BW-1:0] sel);
    onehot      = '0;
    onehot[sel] = 1'b1;
  endfunction

  // prev_q tracks the synchronized buttons continuously, so a button held across
  // reset release or game start never looks like a fresh rising edge in INPUT.
  assign rise      = sync2_q & ~prev_q;
  assign show_sel  = seq_q[idx_q[IW-1:0]];
  assign exp_sel   = seq_q[ptr_q[IW-1:0]];
  assign lfsr_next = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  always_ff @(posedge hz100) begin
    if (!reset) begin
      state_q <= S_IDLE;
      lfsr_q  <= LFSR_INIT;
      level_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      level_q <= level_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
      sync1_q <= bus.btn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Sequence memory is never reset: an entry is always written by GEN before replay reads it.
  always_ff @(posedge hz100) begin
    if (seq_we) seq_q[level_q[IW-1:0]] <= lfsr_q[BW-1:0];
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    level_d = level_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    lose_d  = lose_q;
    seq_we  = 1'b0;
    led_c   = '0;

    case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (state_q == S_WIN) led_c = '1;
        if (bus.start) begin
          lfsr_d  = (bus.seed == 16'h0000) ? LFSR_INIT : bus.seed;
          win_d   = 1'b0;
          lose_d  = 1'b0;
          level_d = '0;
          cnt_d   = '0;
          state_d = S_GEN;
        end
      end
      S_GEN: begin
        seq_we  = 1'b1;
        lfsr_d  = lfsr_next;
        level_d = level_q + 7'd1;
        idx_d   = '0;
        cnt_d   = '0;
        state_d = S_SHOW_OFF;
      end
      S_SHOW_ON: begin
        led_c = onehot(show_sel);
        if (cnt_q == CW'(SHOW_TICKS - 1)) begin
          cnt_d   = '0;
          idx_d   = idx_q + 7'd1;
          state_d = S_SHOW_OFF;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SHOW_OFF: begin
        if (cnt_q == CW'(GAP_TICKS - 1)) begin
          cnt_d = '0;
          if (idx_q < level_q) begin
            state_d = S_SHOW_ON;
          end else begin
            ptr_d   = '0;
            state_d = S_INPUT;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_INPUT: begin
        led_c = sync2_q;
        // A press in the expiry cycle is judged as a press, not as a timeout.
        if (rise != '0) begin
          if (rise == onehot(exp_sel)) begin
            cnt_d = '0;
            if (ptr_q == level_q - 7'd1) begin
              if (level_q == 7'(MAX_LEN)) begin
                win_d   = 1'b1;
                state_d = S_WIN;
              end else begin
                state_d = S_GEN;
              end
            end else begin
              ptr_d = ptr_q + 7'd1;
            end
          end else begin
            lose_d  = 1'b1;
            state_d = S_LOSE;
          end
        end else if (cnt_q == CW'(TIMEOUT_TICKS - 1)) begin
          lose_d  = 1'b1;
          state_d = S_LOSE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.led   = led_c;
  assign bus.state = state_q;
  assign bus.level = level_q;
  assign bus.busy  = (state_q == S_GEN) || (state_q == S_SHOW_ON) ||
                     (state_q == S_SHOW_OFF) || (state_q == S_INPUT);
  assign bus.win   = win_q;
  assign bus.lose  = lose_q;

endmodule

// File: doc/simon_engine.md
SIMON_ENGINE -- requirements
Module: simon_engine

Interface
REQ-001 SHALL have parameter NUM_BTN, default 4, the number of buttons and LEDs; power of two, 2..16.
REQ-002 SHALL have parameter MAX_LEN, default 16, the sequence length that wins the game; range 2..64.
REQ-003 SHALL have parameter SHOW_TICKS, default 50, the clock cycles each sequence LED is lit.
REQ-004 SHALL have parameter GAP_TICKS, default 25, the clock cycles of dark gap after each lit element and before each replay.
REQ-005 SHALL have parameter TIMEOUT_TICKS, default 500, the maximum idle cycles between presses during player input.
REQ-006 SHALL have port hz100, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1; reset is synchronous and active-low.
REQ-008 SHALL have port start, input, 1, a level-sensitive request to begin a game, sampled per cycle.
REQ-009 SHALL have port seed, input, 16, the LFSR seed captured on game start.
REQ-010 SHALL have port btn, input, NUM_BTN, raw asynchronous push buttons.
REQ-011 SHALL have port led, output, NUM_BTN, the sequence display / button echo.
REQ-012 SHALL have port state, output, 3, the current state code.
REQ-013 SHALL have port level, output, 7, the current sequence length, 0 when idle.
REQ-014 SHALL have port busy, output, 1, high in the GEN, SHOW_ON, SHOW_OFF and INPUT states.
REQ-015 SHALL have port win, output, 1, sticky success flag.
REQ-016 SHALL have port lose, output, 1, sticky failure flag.

Function
REQ-017 btn SHALL pass through a 2-flop synchronizer; a press is a 0->1 transition on any synchronized bit. Press is detected 2 cycles after the raw edge at the earliest.
REQ-018 States and state codes SHALL be: IDLE=0, GEN=1, SHOW_ON=2, SHOW_OFF=3, INPUT=4, WIN=5, LOSE=6.
REQ-019 In IDLE, WIN or LOSE, start=1 SHALL perform all of the following:
- load the LFSR with seed, or with 16'hACE1 if seed==0;
- clear win, lose and level;
- enter GEN.
REQ-020 start SHALL be ignored in all other states.
REQ-021 The LFSR SHALL be 16-bit Fibonacci, taps 16,14,13,11, and SHALL advance exactly once per GEN.
REQ-022 GEN SHALL last 1 cycle and perform all of the following:
- write seq[level] = lfsr[log2(NUM_BTN)-1:0];
- increment level;
- clear the replay index;
- enter SHOW_OFF for GAP_TICKS as the pre-replay pause.
REQ-023 SHOW_ON SHALL drive led = onehot(seq[idx]) for exactly SHOW_TICKS cycles, then go to SHOW_OFF.
REQ-024 SHOW_OFF SHALL drive led = 0 for exactly GAP_TICKS cycles. On expiry:
- if a further element remains to show, go to SHOW_ON with the next element;
- otherwise enter INPUT with ptr=0 and the timeout counter cleared.
REQ-025 In INPUT, led SHALL equal the synchronized btn.
REQ-026 In INPUT, the press cases SHALL be handled as follows:
- a press whose rising-bit vector is exactly onehot(seq[ptr]) is correct: ptr increments and the timeout counter clears;
- any other rising vector (wrong bit, or two or more bits rising in the same cycle) SHALL enter LOSE next cycle.
REQ-027 A correct press at ptr==level-1 completes the level:
- if level==MAX_LEN, enter WIN;
- otherwise enter GEN.
REQ-028 The timeout counter SHALL reaching TIMEOUT_TICKS without a press enter LOSE; a press in the same cycle as expiry takes priority.
REQ-029 In WIN, win=1 and led = all-ones. In LOSE, lose=1 and led=0.
REQ-030 In WIN and LOSE, level SHALL hold its last value.
REQ-031 Sequence storage SHALL be MAX_LEN entries of log2(NUM_BTN) bits, not cleared by reset; entries are written before being read.
REQ-032 Timer counters SHALL be wide enough for max(SHOW_TICKS, GAP_TICKS, TIMEOUT_TICKS) with no wrap.

Reset
REQ-033 While reset==0 on a clock edge, the block SHALL apply the following next cycle:
- state=IDLE;
- led=0, level=0, busy=0, win=0, lose=0;
- LFSR=16'hACE1;
- synchronizer flops and all counters = 0.
REQ-034 Reset asserted mid-game SHALL abort in one cycle with no residual LED output; a button held through reset release SHALL NOT register as a press.

Verification (NUM_BTN=4, MAX_LEN=3, SHOW_TICKS=2, GAP_TICKS=1, TIMEOUT_TICKS=10)
REQ-035 Reset and start: reset low for 2 cycles, then start=1 with seed=0 -> state 0->1->3; level=1; LFSR=16'hACE1 before its first step; busy=1.
REQ-036 Replay timing: level 2 -> led pattern, cycle-exact, is 1 gap, 2 on, 1 gap, 2 on, 1 gap, then INPUT.
REQ-037 Full win: press the correct sequence at every level -> win=1, led=4'b1111, level=3, state=5. A following start restarts the game with level=1.
REQ-038 Wrong and double press:
- a wrong button at ptr=0 -> state=6, lose=1, led=0;
- in a separate run, btn=4'b0011 rising together -> LOSE.
REQ-039 Timeout: no press for 10 cycles in INPUT -> LOSE. A correct press on cycle 10 -> remains in INPUT with ptr advanced.
REQ-040 Ignore and abort: start pulsed during SHOW_ON -> no effect. reset asserted during INPUT -> all outputs zero next cycle, state=0.
